weight_fetch_ctrl: RTL and testbench
====================================

// Module: weight_fetch_ctrl
// PURPOSE
//  Read sequencer that sits directly upstream of the weight BRAM and downstream of the layer controller.
//  On a start pulse it streams num_words consecutive weights from base_addr, driving the BRAM addr/rd_en.
//  It captures the BRAM dout/valid into a credit-protected FIFO.
//  Weights go to the MAC array over a valid/ready stream; no data is lost under backpressure.
// PARAMETERS
//  DATA_WIDTH  16    weight word width; equals BRAM DATA_WIDTH
//  DEPTH       4096  BRAM depth in words
//  ADDR_WIDTH  12    $clog2(DEPTH)
//  FIFO_DEPTH  4     output FIFO entries; power of two, >=2
// PORTS
//  clk         in   1             clock
//  rst_n       in   1             asynchronous active-low reset
//  start       in   1             one-cycle request; sampled only in IDLE
//  base_addr   in   ADDR_WIDTH    first word address; sampled with start
//  num_words   in   ADDR_WIDTH+1  word count, 0..DEPTH; sampled with start
//  busy        out  1             high from the cycle after start until done
//  done        out  1             one-cycle completion pulse
//  bram_addr   out  ADDR_WIDTH    to BRAM addr
//  bram_rd_en  out  1             to BRAM rd_en
//  bram_dout   in   DATA_WIDTH    from BRAM dout
//  bram_valid  in   1             from BRAM valid; exactly 1 cycle after rd_en
//  w_data      out  DATA_WIDTH    weight to MAC array (FIFO head)
//  w_valid     out  1             FIFO non-empty
//  w_ready     in   1             consumer accept; transfer = w_valid & w_ready
//  w_last      out  1             high with the final word of the request
// BEHAVIOUR
//  Reset values: busy=0, done=0, bram_addr=0, bram_rd_en=0, w_valid=0, w_data=0, w_last=0.
//  Reset also clears FIFO, counters and in-flight flag; FSM returns to IDLE.
//  Reset is legal mid-request; the request is dropped.
//  FSM states and transitions:
//   IDLE -> FETCH on start with num_words!=0.
//   IDLE -> DONE on start with num_words==0; no rd_en is ever issued.
//   FETCH: issues reads; -> DRAIN in the cycle the last read is issued.
//   DRAIN: waits for the last in-flight read and FIFO empty; -> DONE on the final w handshake.
//   DONE: done=1 for one cycle, busy=0; -> IDLE.
//   start is ignored outside IDLE.
//  Read issue (FETCH): bram_rd_en=1 when fifo_count + inflight < FIFO_DEPTH.
//   inflight = rd_en issued the previous cycle; this is the credit rule.
//   bram_addr advances +1 per issued read and wraps modulo DEPTH (0xFFF -> 0x000).
//  First rd_en occurs the cycle after start; bram_valid pushes bram_dout into the FIFO.
//  w_valid rises the cycle after bram_valid: start-to-first-w_valid = 3 cycles.
//  With w_ready held high: one word per cycle sustained; no bubbles after the first word.
//  Simultaneous FIFO push and pop: count unchanged, order preserved.
//  Overflow is impossible by credit; a push into a full FIFO is a design error (assert in sim).
//  w_last is derived from a word counter of handshakes; it is high only on word num_words-1.
//  w_data/w_valid hold stable while w_valid & !w_ready.
//  done is asserted the cycle after the last handshake; busy goes low in that same cycle.
// CONFIGURATION
//  WFETCH_ABORT_EN defined: adds input abort (1 bit).
//   abort=1 in FETCH/DRAIN stops read issue immediately and flushes the FIFO.
//   The in-flight bram_valid word is discarded; w_valid=0 from the next cycle.
//   FSM -> IDLE next cycle; done is NOT pulsed. abort is ignored in IDLE/DONE.
//  WFETCH_ABORT_EN undefined: no abort port; every accepted request runs to done.
// TESTING
//  1 base=0x010, num=8, w_ready=1: rd addrs 0x010..0x017 on consecutive cycles.
//    w_data = mem[0x010..0x017] in order; w_last on the 8th word; done 1 cycle later.
//  2 base=0x000, num=16, w_ready low 10 cycles then high: <=4 reads before first pop.
//    All 16 words in order; no FIFO overflow.
//  3 base=0xFFE, num=4: bram_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; w_last on mem[0x001].
//  4 num=0: done pulses 1 cycle after start; bram_rd_en never asserts.
//    A second start while busy (num=2 request) is ignored.
//  5 rst_n low after 3 words of num=10: all outputs at reset values asynchronously.
//    A new start base=0x100 num=2 then completes normally.
//  6 WFETCH_ABORT_EN defined, abort after 2 of 8 words with w_ready=1:
//    w_valid=0 next cycle, no done, busy=0, no further rd_en.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
// Weight BRAM read sequencer: streams num_words reads from base_addr into a credit-protected
// output FIFO feeding the MAC array. Optional abort port enabled by defining WFETCH_ABORT_EN.
module weight_fetch_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
`ifdef WFETCH_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_rd_en,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  input  logic                  bram_valid,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH:0] ONE_W = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [CW:0]           credit_sum;
  logic                  credit_ok;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic                  abort_w;
  logic [ADDR_WIDTH:0]   rd_left;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH-1:0] next_addr;

`ifdef WFETCH_ABORT_EN
  assign abort_w = abort & ((state == S_FETCH) | (state == S_DRAIN));
`else
  assign abort_w = 1'b0;
`endif

  // Only reads we actually issued (and did not abort) may land in the FIFO.
  assign push    = bram_valid & inflight & ~abort_w;
  assign w_valid = (fifo_cnt != '0);
  assign pop     = w_valid & w_ready;
  assign w_data  = w_valid ? fifo_mem[rd_ptr] : '0;
  assign w_last  = w_valid & (word_cnt == (num_q - ONE_W));

  // Credit: entries after this edge plus the read still in flight must leave room for one more.
  assign cnt_nxt    = fifo_cnt + CW'(push) - CW'(pop);
  assign credit_sum = {1'b0, cnt_nxt} + (CW+1)'(bram_rd_en);
  assign credit_ok  = (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign next_addr  = (bram_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : bram_addr + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort_w) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) begin
      assert (fifo_cnt != CW'(FIFO_DEPTH))
        else $error("weight FIFO overflow");
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bram_addr  <= '0;
      bram_rd_en <= 1'b0;
      inflight   <= 1'b0;
      rd_left    <= '0;
      word_cnt   <= '0;
      num_q      <= '0;
    end else begin
      inflight <= bram_rd_en & ~abort_w;
      done     <= 1'b0;
      if (pop) word_cnt <= word_cnt + ONE_W;
      case (state)
        S_IDLE: begin
          bram_rd_en <= 1'b0;
          if (start) begin
            num_q    <= num_words;
            word_cnt <= '0;
            if (num_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= (num_words == ONE_W) ? S_DRAIN : S_FETCH;
              busy       <= 1'b1;
              bram_rd_en <= 1'b1;
              bram_addr  <= base_addr;
              rd_left    <= num_words - ONE_W;
            end
          end
        end
        S_FETCH: begin
          if (abort_w) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            bram_rd_en <= 1'b0;
          end else if (credit_ok && (rd_left != '0)) begin
            bram_rd_en <= 1'b1;
            bram_addr  <= next_addr;
            rd_left    <= rd_left - ONE_W;
            if (rd_left == ONE_W) state <= S_DRAIN;
          end else begin
            bram_rd_en <= 1'b0;
          end
        end
        S_DRAIN: begin
          bram_rd_en <= 1'b0;
          if (abort_w) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (pop && w_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          bram_rd_en <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: BRAM model plus a queue-based expected stream.
module tb_weight_fetch_ctrl;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int DEPTH = 4096;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;
  logic [AW-1:0] bram_addr;
  logic          bram_rd_en;
  logic [DW-1:0] bram_dout = '0;
  logic          bram_valid = 1'b0;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;
`ifdef WFETCH_ABORT_EN
  logic          abort;
`endif

  weight_fetch_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
`ifdef WFETCH_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_rd_en(bram_rd_en),
    .bram_dout(bram_dout), .bram_valid(bram_valid), .w_data(w_data), .w_valid(w_valid),
    .w_ready(w_ready), .w_last(w_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    bram_valid <= bram_rd_en;
    bram_dout  <= mem[bram_addr];
  end

  function automatic void chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endfunction

  // Reference: the request is simply the list of addresses base+i mod DEPTH and their contents.
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_addr[$];
  int exp_num, pop_idx, rd_issued, first_v_cyc, last_hs_cyc, done_cyc;
  logic stalled_p = 1'b0;
  logic [DW-1:0] stalled_d;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_rd_en) begin
        chk("rd_expected", 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) begin
          chk("rd_addr", 32'(bram_addr), 32'(exp_addr[0]));
          void'(exp_addr.pop_front());
        end
        rd_issued++;
        chk("credit", 32'(rd_issued - pop_idx <= FD), 32'd1);
      end
      if (w_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (stalled_p) chk("hold", {15'd0, w_valid, w_data}, {15'd0, 1'b1, stalled_d});
      stalled_p = w_valid && !w_ready;
      stalled_d = w_data;
      if (w_valid && w_ready) begin
        chk("w_expected", 32'(exp_data.size() > 0), 32'd1);
        if (exp_data.size() > 0) begin
          chk("w_data", 32'(w_data), 32'(exp_data[0]));
          chk("w_last", 32'(w_last), 32'(pop_idx == exp_num - 1));
          void'(exp_data.pop_front());
        end
        pop_idx++;
        if (pop_idx == exp_num) last_hs_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end else begin
      stalled_p = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_val(int mode, int k, int stall);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom % 4) != 0;
    return k >= stall;
  endfunction

  task automatic setup_model(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    exp_data.delete();
    exp_addr.delete();
    exp_num = n; pop_idx = 0; rd_issued = 0;
    first_v_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_addr"}, 32'(bram_addr), 32'd0);
    chk({tag, "_rd_en"}, 32'(bram_rd_en), 32'd0);
    chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
    chk({tag, "_w_data"}, 32'(w_data), 32'd0);
    chk({tag, "_w_last"}, 32'(w_last), 32'd0);
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for `stall` cycles then high.
  task automatic run_req(input logic [AW-1:0] b, input int n, input int mode, input int stall,
                         input bit extra_start);
    int s;
    int k;
    setup_model(b, n);
    w_ready   = ready_val(mode, 0, stall);
    start     = 1'b1;
    base_addr = b;
    num_words = (AW+1)'(n);
    tick();
    start     = 1'b0;
    s = cyc;
    chk("busy_after_start", 32'(busy), 32'(n != 0));
    k = 0;
    while (done_cyc < 0 && k < 3000) begin
      w_ready   = ready_val(mode, k + 1, stall);
      start     = extra_start && (k == 1);
      base_addr = b + AW'(100);
      num_words = (AW+1)'(7);
      if (mode == 2 && k == stall - 1) chk("reads_before_pop", 32'(rd_issued), 32'(FD));
      tick();
      k++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    if (n == 0) begin
      chk("done_latency_n0", 32'(done_cyc), 32'(s));
      chk("no_reads_n0", 32'(rd_issued), 32'd0);
    end else begin
      chk("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
      chk("words_popped", 32'(pop_idx), 32'(n));
      chk("reads_all", 32'(exp_addr.size()), 32'd0);
      if (mode == 0) chk("first_valid_lat", 32'(first_v_cyc), 32'(s + 2));
    end
    chk("done_one_cycle", 32'(done), 32'd0);
    w_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; w_ready = 1'b1;
`ifdef WFETCH_ABORT_EN
    abort = 1'b0;
`endif
    setup_model('0, 0);
    tick(); tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_req(12'h010, 8, 0, 0, 1'b0);
    run_req(12'h000, 16, 2, 10, 1'b0);
    run_req(12'hFFE, 4, 0, 0, 1'b0);
    run_req(12'h055, 0, 0, 0, 1'b0);
    run_req(12'h300, 2, 0, 0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("idle_no_reads", 32'(rd_issued), 32'd2);

    // Reset mid-request, then a fresh request.
    begin
      int k;
      setup_model(12'h200, 10);
      start = 1'b1; base_addr = 12'h200; num_words = 13'd10;
      tick();
      start = 1'b0;
      k = 0;
      while (pop_idx < 3 && k < 100) begin tick(); k++; end
      chk("mid_req_words", 32'(pop_idx >= 3), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      tick(); tick();
      rst_n = 1'b1;
      tick();
    end
    run_req(12'h100, 2, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_req(AW'($urandom), 1 + int'($urandom % 24), 1, 0, 1'b0);
    end

`ifdef WFETCH_ABORT_EN
    begin
      int k;
      int rd_snap;
      setup_model(12'h400, 8);
      start = 1'b1; base_addr = 12'h400; num_words = 13'd8;
      tick();
      start = 1'b0;
      k = 0;
      while (pop_idx < 2 && k < 100) begin tick(); k++; end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_w_valid", 32'(w_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      rd_snap = rd_issued;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("abort_w_valid_hold", 32'(w_valid), 32'd0);
      end
      chk("abort_no_reads", 32'(rd_issued), 32'(rd_snap));
      chk("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    end
    run_req(12'h123, 3, 0, 0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
